// File: rtl/cam_line_capture_pkg.sv
// Shared types and constants for the camera line-capture stage.
// Holds the FSM state encoding, the byte order and the bank-size helper.
package cam_capture_pkg;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        WAIT_LINE  = 2'd1,
        HIGH_BYTE  = 2'd2,
        LOW_BYTE   = 2'd3
    } cap_state_t;

    // The OV7670 sends RGB565 with the high byte first.
    localparam bit HIGH_BYTE_FIRST = 1'b1;

    function automatic int bank_words(input int addr_w);
        return 1 << (addr_w - 1);
    endfunction

    function automatic logic [15:0] pack_pixel(input logic [7:0] first_byte,
                                               input logic [7:0] second_byte);
        return HIGH_BYTE_FIRST ? {first_byte, second_byte} : {second_byte, first_byte};
    endfunction

endpackage

// File: rtl/cam_line_capture_if.sv
// Camera input bus plus RAM write port and line status of the capture stage.
// The master side is the capture block; the slave side is the camera/RAM/reader.
interface cam_line_capture_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
);
    import cam_capture_pkg::*;

    logic              enable;
    logic              cam_vsync;
    logic              cam_href;
    logic [7:0]        cam_data;

    // wren is a one-cycle strobe with no back-pressure: data and wraddress are
    // valid exactly in the cycle wren is high, and the RAM always accepts them.
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] wraddress;
    logic              wren;
    logic              line_ready;
    logic              line_bank;
    logic [9:0]        line_count;
    logic              frame_done;
    logic              overflow;
    logic              short_line;
    cap_state_t        state;

    modport master (
        input  enable, cam_vsync, cam_href, cam_data,
        output data, wraddress, wren, line_ready, line_bank, line_count,
               frame_done, overflow, short_line, state
    );

    modport slave (
        output enable, cam_vsync, cam_href, cam_data,
        input  data, wraddress, wren, line_ready, line_bank, line_count,
               frame_done, overflow, short_line, state
    );

endinterface

// File: rtl/sync_edge_reg.sv
// Registers the camera inputs and derives VSYNC/HREF edge strobes.
// All strobes line up with dout, except hr_rise which leads it by one cycle.
module sync_edge_reg (
    input  logic       clock,
    input  logic       reset,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       vs_rise,
    output logic       vs_fall,
    output logic       hr_rise,
    output logic       hr_fall
);

    logic       vs_r, vs_q, vs_qq;
    logic       hr_r, hr_q, hr_qq;
    logic [7:0] d_r, d_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vs_r  <= 1'b0;
            vs_q  <= 1'b0;
            vs_qq <= 1'b0;
            hr_r  <= 1'b0;
            hr_q  <= 1'b0;
            hr_qq <= 1'b0;
            d_r   <= 8'h00;
            d_q   <= 8'h00;
        end else begin
            vs_r  <= vsync;
            vs_q  <= vs_r;
            vs_qq <= vs_q;
            hr_r  <= href;
            hr_q  <= hr_r;
            hr_qq <= hr_q;
            d_r   <= din;
            d_q   <= d_r;
        end
    end

    // hr_rise fires while the first byte is still one stage early, so the FSM
    // is already in HIGH_BYTE when that byte reaches dout.
    assign dout    = d_q;
    assign vs_rise =  vs_q & ~vs_qq;
    assign vs_fall = ~vs_q &  vs_qq;
    assign hr_rise =  hr_r & ~hr_q;
    assign hr_fall = ~hr_q &  hr_qq;

endmodule

// File: rtl/cam_line_capture.sv
// Frames an OV7670 byte stream into RGB565 pixels and writes each line into one
// half of a ping-pong line buffer, flagging completed lines to the reader.
module cam_line_capture
    import cam_capture_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 11,
    parameter int LINE_PIXELS = 640
) (
    input  logic                 clock,
    input  logic                 reset,
    cam_line_capture_if.master   bus
);

    localparam int LIMIT = (LINE_PIXELS < bank_words(ADDR_W)) ? LINE_PIXELS
                                                              : bank_words(ADDR_W);
    localparam logic [ADDR_W-1:0] LIMIT_C = ADDR_W'(LIMIT);

    logic [7:0] byte_q;
    logic       vs_rise, vs_fall, hr_rise, hr_fall;

    sync_edge_reg u_sync (
        .clock   (clock),
        .reset   (reset),
        .vsync   (bus.cam_vsync),
        .href    (bus.cam_href),
        .din     (bus.cam_data),
        .dout    (byte_q),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall),
        .hr_rise (hr_rise),
        .hr_fall (hr_fall)
    );

    cap_state_t        state, state_n;
    logic              line_start, latch_hi, do_write, do_ovf;
    logic              do_ready, do_short, frame_start, frame_end;

    logic [ADDR_W-1:0] pix_cnt;
    logic [7:0]        hi_byte;
    logic              bank;
    logic [DATA_W-1:0] data_r;
    logic [ADDR_W-1:0] wraddress_r;
    logic              wren_r, line_ready_r, line_bank_r, frame_done_r;
    logic              overflow_r, short_line_r;
    logic [9:0]        line_count_r;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= WAIT_FRAME;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        line_start  = 1'b0;
        latch_hi    = 1'b0;
        do_write    = 1'b0;
        do_ovf      = 1'b0;
        do_ready    = 1'b0;
        do_short    = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            WAIT_FRAME: begin
                if (vs_fall && bus.enable) begin
                    frame_start = 1'b1;
                    state_n     = WAIT_LINE;
                end
            end
            WAIT_LINE: begin
                if (vs_rise) begin
                    frame_end = 1'b1;
                    state_n   = WAIT_FRAME;
                end else if (hr_rise) begin
                    line_start = 1'b1;
                    state_n    = HIGH_BYTE;
                end
            end
            HIGH_BYTE, LOW_BYTE: begin
                // VSYNC aborts a partial line silently; only frame_done reports it.
                if (vs_rise) begin
                    frame_end = 1'b1;
                    state_n   = WAIT_FRAME;
                end else if (hr_fall) begin
                    // Sitting in LOW_BYTE here means an odd byte count.
                    if (state == HIGH_BYTE && pix_cnt >= LIMIT_C) do_ready = 1'b1;
                    else                                          do_short = 1'b1;
                    state_n = WAIT_LINE;
                    if (hr_rise) begin
                        line_start = 1'b1;
                        state_n    = HIGH_BYTE;
                    end
                end else if (state == HIGH_BYTE) begin
                    latch_hi = 1'b1;
                    state_n  = LOW_BYTE;
                end else begin
                    if (pix_cnt < LIMIT_C) do_write = 1'b1;
                    else                   do_ovf   = 1'b1;
                    state_n = HIGH_BYTE;
                end
            end
            default: state_n = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_cnt      <= '0;
            hi_byte      <= 8'h00;
            bank         <= 1'b0;
            data_r       <= '0;
            wraddress_r  <= '0;
            wren_r       <= 1'b0;
            line_ready_r <= 1'b0;
            line_bank_r  <= 1'b0;
            frame_done_r <= 1'b0;
            overflow_r   <= 1'b0;
            short_line_r <= 1'b0;
            line_count_r <= '0;
        end else begin
            wren_r       <= do_write;
            line_ready_r <= do_ready;
            frame_done_r <= frame_end;
            if (frame_start) begin
                line_count_r <= '0;
                bank         <= 1'b0;
            end
            if (line_start) pix_cnt <= '0;
            if (latch_hi)   hi_byte <= byte_q;
            if (do_write) begin
                data_r      <= pack_pixel(hi_byte, byte_q);
                wraddress_r <= {bank, pix_cnt[ADDR_W-2:0]};
                pix_cnt     <= pix_cnt + 1'b1;
            end
            if (do_ready) begin
                line_bank_r <= bank;
                bank        <= ~bank;
                if (line_count_r != 10'h3FF) line_count_r <= line_count_r + 10'd1;
            end
            if (do_ovf)   overflow_r   <= 1'b1;
            if (do_short) short_line_r <= 1'b1;
        end
    end

    assign bus.data       = data_r;
    assign bus.wraddress  = wraddress_r;
    assign bus.wren       = wren_r;
    assign bus.line_ready = line_ready_r;
    assign bus.line_bank  = line_bank_r;
    assign bus.line_count = line_count_r;
    assign bus.frame_done = frame_done_r;
    assign bus.overflow   = overflow_r;
    assign bus.short_line = short_line_r;
    assign bus.state      = state;

endmodule

// File: tb/tb_cam_line_capture.sv
// Directed-plus-random bench for cam_line_capture: whole lines are checked
// against a line-level model of the capture rules (writes, banks, flags).
module tb_cam_line_capture;
    import cam_capture_pkg::*;

    localparam int LINE = 640;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    cam_line_capture_if #(.DATA_W(16), .ADDR_W(11)) bus ();

    cam_line_capture #(.DATA_W(16), .ADDR_W(11), .LINE_PIXELS(LINE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    // observed activity
    logic [26:0] act_q[$];
    bit          act_rdy[$];
    int          fd_cnt = 0, b2b = 0, first_wr_cyc = 0, rdy_cyc = 0, fd_cyc = 0;
    logic        prev_wren = 1'b0;

    // reference model state
    logic [26:0] exp_q[$];
    bit          exp_rdy[$];
    bit          bank_m = 1'b0, active_m = 1'b0, ovf_m = 1'b0, short_m = 1'b0;
    int          count_m = 0, fd_exp = 0;
    int          low_edge = 0, fall_edge = 0, v_edge = 0;
    logic [7:0]  part_b[$];
    logic [7:0]  b;
    int          found;

    always @(negedge clock) begin
        if (bus.wren === 1'b1) begin
            act_q.push_back({bus.wraddress, bus.data});
            if (first_wr_cyc == 0) first_wr_cyc = cyc;
            if (prev_wren) b2b++;
        end
        prev_wren = (bus.wren === 1'b1);
        if (bus.line_ready === 1'b1) begin
            act_rdy.push_back(bus.line_bank);
            rdy_cyc = cyc;
        end
        if (bus.frame_done === 1'b1) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout cycles=%0d limit_reached", cyc);
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // A line of bytes, as the spec's end-of-line rules see it.
    task automatic model_line(input logic [7:0] bq[$]);
        int npix, nw;
        if (!active_m) return;
        npix = bq.size() / 2;
        nw   = (npix < LINE) ? npix : LINE;
        for (int k = 0; k < nw; k++)
            exp_q.push_back({bank_m, 10'(k), bq[2*k], bq[2*k+1]});
        if (npix > LINE) ovf_m = 1'b1;
        if (bq.size() % 2 == 0 && npix >= LINE) begin
            exp_rdy.push_back(bank_m);
            bank_m = ~bank_m;
            if (count_m < 1023) count_m++;
        end else begin
            short_m = 1'b1;
        end
    endtask

    task automatic drive_line(input int n, input bit rnd, input logic [7:0] a, input logic [7:0] c);
        logic [7:0] bq[$];
        for (int i = 0; i < n; i++)
            bq.push_back(rnd ? 8'($urandom) : ((i % 2 == 0) ? a : c));
        model_line(bq);
        first_wr_cyc = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.cam_href = 1'b1;
            bus.cam_data = bq[i];
            if (i == 1) low_edge = cyc + 1;
        end
        @(negedge clock);
        bus.cam_href = 1'b0;
        bus.cam_data = 8'($urandom);
        fall_edge    = cyc + 1;
        idle(10);
    endtask

    task automatic frame_start(input bit en);
        @(negedge clock);
        bus.enable    = en;
        bus.cam_vsync = 1'b1;
        idle(4);
        bus.cam_vsync = 1'b0;
        idle(4);
        if (en) begin
            active_m = 1'b1;
            bank_m   = 1'b0;
            count_m  = 0;
        end
    endtask

    task automatic frame_end();
        @(negedge clock);
        bus.cam_vsync = 1'b1;
        v_edge        = cyc + 1;
        idle(6);
        if (active_m) begin
            fd_exp++;
            active_m = 1'b0;
        end
    endtask

    task automatic check_line(input string tag);
        int          bad, n;
        logic [26:0] fa, fe;
        bad = 0;
        fa  = '0;
        fe  = '0;
        chk({tag, "_wr_count"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (act_q[i] !== exp_q[i]) begin
                if (bad == 0) begin
                    fa = act_q[i];
                    fe = exp_q[i];
                end
                bad++;
            end
        end
        checks++;
        assert (bad === 0) else begin
            failures++;
            $error("FAIL %s_wr_data observed=%h expected=%h mismatches=%0d", tag, fa, fe, bad);
        end
        chk({tag, "_rdy_count"}, act_rdy.size(), exp_rdy.size());
        n = (act_rdy.size() < exp_rdy.size()) ? act_rdy.size() : exp_rdy.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_rdy_bank"}, act_rdy[i], exp_rdy[i]);
        chk({tag, "_line_count"}, bus.line_count, count_m);
        chk({tag, "_overflow"}, bus.overflow, ovf_m);
        chk({tag, "_short_line"}, bus.short_line, short_m);
        act_q.delete();
        exp_q.delete();
        act_rdy.delete();
        exp_rdy.delete();
    endtask

    initial begin
        bus.enable    = 1'b0;
        bus.cam_vsync = 1'b0;
        bus.cam_href  = 1'b0;
        bus.cam_data  = 8'h00;
        reset         = 1'b1;
        idle(4);
        chk("rst_wren", bus.wren, 0);
        chk("rst_line_ready", bus.line_ready, 0);
        chk("rst_line_bank", bus.line_bank, 0);
        chk("rst_line_count", bus.line_count, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_short_line", bus.short_line, 0);
        chk("rst_data", bus.data, 0);
        chk("rst_wraddress", bus.wraddress, 0);
        chk("rst_state", bus.state, WAIT_FRAME);
        reset = 1'b0;
        idle(2);

        frame_start(1'b1);
        drive_line(1280, 1'b0, 8'hFF, 8'hFE);
        chk("lat_wr", first_wr_cyc, low_edge + 2);
        chk("lat_rdy", rdy_cyc, fall_edge + 2);
        check_line("full_bank0");
        drive_line(1280, 1'b0, 8'h67, 8'h68);
        check_line("full_bank1");
        drive_line(1280, 1'b1, 8'h00, 8'h00);
        check_line("full_back0");
        drive_line(101, 1'b1, 8'h00, 8'h00);
        check_line("short");
        drive_line(1280, 1'b1, 8'h00, 8'h00);
        check_line("after_short");
        drive_line(1284, 1'b1, 8'h00, 8'h00);
        check_line("overflow");
        for (int r = 0; r < 3; r++) begin
            drive_line($urandom_range(1250, 1290), 1'b1, 8'h00, 8'h00);
            check_line("rand_len");
        end

        // VSYNC rises while byte 300 of a line is on the bus
        part_b.delete();
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            b            = 8'($urandom);
            bus.cam_href = 1'b1;
            bus.cam_data = b;
            if (i < 300) part_b.push_back(b);
            if (i == 300) begin
                bus.cam_vsync = 1'b1;
                v_edge        = cyc + 1;
            end
        end
        for (int k = 0; k < part_b.size() / 2; k++)
            exp_q.push_back({bank_m, 10'(k), part_b[2*k], part_b[2*k+1]});
        fd_exp++;
        active_m = 1'b0;
        @(negedge clock);
        bus.cam_href = 1'b0;
        idle(10);
        check_line("abort");
        chk("abort_frame_done", fd_cnt, fd_exp);
        chk("lat_frame_done", fd_cyc, v_edge + 2);
        chk("abort_state", bus.state, WAIT_FRAME);

        frame_start(1'b0);
        drive_line(1280, 1'b1, 8'h00, 8'h00);
        check_line("disabled");
        frame_end();
        chk("disabled_frame_done", fd_cnt, fd_exp);

        frame_start(1'b1);
        drive_line(1280, 1'b1, 8'h00, 8'h00);
        check_line("new_frame");
        frame_end();
        chk("new_frame_done", fd_cnt, fd_exp);
        chk("lat_frame_done2", fd_cyc, v_edge + 2);

        // reset in the middle of a line
        frame_start(1'b1);
        drive_line(1280, 1'b1, 8'h00, 8'h00);
        check_line("pre_reset");
        found = 0;
        for (int i = 0; i < 1280 && found == 0; i++) begin
            @(negedge clock);
            bus.cam_href = 1'b1;
            bus.cam_data = 8'($urandom);
            if (i >= 40 && bus.state == LOW_BYTE) found = 1;
        end
        chk("rst_reach_low", found, 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_wren", bus.wren, 0);
        chk("midrst_line_count", bus.line_count, 0);
        chk("midrst_overflow", bus.overflow, 0);
        chk("midrst_short_line", bus.short_line, 0);
        chk("midrst_state", bus.state, WAIT_FRAME);
        act_q.delete();
        act_rdy.delete();
        active_m = 1'b0;
        bank_m   = 1'b0;
        count_m  = 0;
        ovf_m    = 1'b0;
        short_m  = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (200) begin
            @(negedge clock);
            bus.cam_data = 8'($urandom);
        end
        bus.cam_href = 1'b0;
        idle(10);
        check_line("post_reset");
        frame_start(1'b1);
        drive_line(1280, 1'b1, 8'h00, 8'h00);
        check_line("resume");
        frame_end();

        chk("wren_cadence", b2b, 0);
        chk("final_frame_done", fd_cnt, fd_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
